// File: rtl/fb_writer.sv
// Frame-buffer writer: CPU-mapped cursor/pixel/fill registers driving the write
// port of a 256x256 RGB332 frame-buffer BRAM, one pixel per cycle.
module fb_writer #(
  parameter int FILL_W = 17
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  output logic [31:0] rdata,
  output logic        bram_en,
  output logic        bram_we,
  output logic [15:0] bram_addr,
  output logic [7:0]  bram_wdata,
  output logic        busy
);

  typedef enum logic {IDLE, FILL} state_e;

  localparam logic [2:0] A_CURSOR = 3'd0;
  localparam logic [2:0] A_PIXEL  = 3'd1;
  localparam logic [2:0] A_COLOR  = 3'd2;
  localparam logic [2:0] A_FILL   = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_XY     = 3'd5;

  state_e              state_q, state_d;
  logic [15:0]         cursor_q, cursor_d;
  logic [7:0]          color_q, color_d;
  logic [FILL_W-1:0]   remain_q, remain_d;
  logic                dropped_q, dropped_d;
  logic                bram_en_q, bram_en_d;
  logic [15:0]         bram_addr_q, bram_addr_d;
  logic [7:0]          bram_wdata_q, bram_wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                bus_wr;
  logic [FILL_W-1:0]   fill_n;

  assign busy   = (state_q == FILL);
  assign bus_wr = valid & wstrb;
  assign fill_n = wdata[FILL_W-1:0];

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    color_d      = color_q;
    remain_d     = remain_q;
    dropped_d    = dropped_q;
    bram_en_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    rdata_d      = (addr == A_STATUS) ? {cursor_q, 14'd0, dropped_q, busy} : 32'd0;

    unique case (state_q)
      IDLE: begin
        if (bus_wr) begin
          unique case (addr)
            A_CURSOR: cursor_d = wdata[15:0];
            A_PIXEL: begin
              bram_en_d    = 1'b1;
              bram_addr_d  = cursor_q;
              bram_wdata_d = wdata[7:0];
              cursor_d     = cursor_q + 16'd1;
            end
            A_COLOR:  color_d = wdata[7:0];
            A_FILL: begin
              // The first fill pixel is issued on the accepting edge, so the
              // remaining count excludes it and busy spans exactly N cycles.
              if (fill_n != '0) begin
                state_d      = FILL;
                bram_en_d    = 1'b1;
                bram_addr_d  = cursor_q;
                bram_wdata_d = color_q;
                cursor_d     = cursor_q + 16'd1;
                remain_d     = fill_n - FILL_W'(1);
              end
            end
            A_STATUS: dropped_d = 1'b0;
            A_XY:     cursor_d  = {wdata[15:8], wdata[7:0]};
            default: ;
          endcase
        end
      end
      FILL: begin
        if (remain_q == '0) begin
          state_d = IDLE;
        end else begin
          bram_en_d    = 1'b1;
          bram_addr_d  = cursor_q;
          bram_wdata_d = color_q;
          cursor_d     = cursor_q + 16'd1;
          remain_d     = remain_q - FILL_W'(1);
        end
        if (bus_wr) begin
          unique case (addr)
            A_STATUS:                                  dropped_d = 1'b0;
            A_CURSOR, A_PIXEL, A_COLOR, A_FILL, A_XY: dropped_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset clears the BRAM strobe at once, which aborts a fill in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cursor_q     <= '0;
      color_q      <= '0;
      remain_q     <= '0;
      dropped_q    <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      color_q      <= color_d;
      remain_q     <= remain_d;
      dropped_q    <= dropped_d;
      bram_en_q    <= bram_en_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign bram_en    = bram_en_q;
  assign bram_we    = bram_en_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: bus writes/reads driven on falling edges,
// outputs compared on falling edges, BRAM writes counted on rising edges.
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        wstrb;
  logic [31:0] rdata;
  logic        bram_en;
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [7:0]  bram_wdata;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int wr_cnt = 0;
  int base;
  logic [31:0] st;

  fb_writer #(.FILL_W(17)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .valid      (valid),
    .addr       (addr),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .rdata      (rdata),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en && bram_we) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge; a write leaves its inputs
  // asserted so consecutive calls give back-to-back bus cycles.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid = 1'b0; wstrb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_status(output logic [31:0] v);
    valid = 1'b1; wstrb = 1'b0; addr = 3'd4;
    @(negedge clk);
    v = rdata;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    valid = 1'b0; wstrb = 1'b0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; valid = 1'b0; wstrb = 1'b0; addr = 3'd4; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bram",  {14'd0, bram_en, bram_we, bram_addr}, 32'd0);
    check("rst_wdata", {24'd0, bram_wdata}, 32'd0);

    // XY write accepted on the very first edge after release, then a pixel.
    resetn = 1'b1;
    wr(3'd5, 32'h0000_0A05);
    base = wr_cnt;
    wr(3'd1, 32'h0000_00E0);
    check("xy_pix_en",   {30'd0, bram_en, bram_we}, 32'd3);
    check("xy_pix_addr", {16'd0, bram_addr}, 32'h0000_0A05);
    check("xy_pix_data", {24'd0, bram_wdata}, 32'h0000_00E0);
    rd_status(st);
    check("xy_status", st, 32'h0A06_0000);
    check("xy_wr_count", wr_cnt - base, 1);
    addr = 3'd0;
    idle(1);
    check("rdata_other_addr", rdata, 32'd0);

    // Cursor wrap across back-to-back pixel writes.
    wr(3'd0, 32'h0000_FFFF);
    wr(3'd1, 32'h0000_001C);
    check("wrap_addr0", {15'd0, bram_en, bram_addr}, 32'h0001_FFFF);
    wr(3'd1, 32'h0000_001C);
    check("wrap_addr1", {15'd0, bram_en, bram_addr}, 32'h0001_0000);
    check("wrap_data1", {24'd0, bram_wdata}, 32'h0000_001C);
    idle(1);
    check("wrap_en_off", {30'd0, bram_en, bram_we}, 32'd0);
    rd_status(st);
    check("wrap_status", st, 32'h0001_0000);

    // Fill of 4 pixels: busy for exactly the four write cycles.
    wr(3'd2, 32'h0000_0003);
    wr(3'd0, 32'h0000_0100);
    base = wr_cnt;
    wr(3'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("fill4_busy", {31'd0, busy}, 32'd1);
      check("fill4_addr", {15'd0, bram_we, bram_addr}, 32'h0001_0100 + i);
      check("fill4_data", {24'd0, bram_wdata}, 32'h0000_0003);
      idle(1);
    end
    check("fill4_done", {30'd0, busy, bram_en}, 32'd0);
    check("fill4_count", wr_cnt - base, 4);
    rd_status(st);
    check("fill4_status", st, 32'h0104_0000);

    // Pixel write during a fill of 8 is dropped; STATUS write clears it.
    base = wr_cnt;
    wr(3'd3, 32'd8);
    idle(2);
    wr(3'd1, 32'h0000_00AA);
    wait_idle(20);
    check("drop_count", wr_cnt - base, 8);
    rd_status(st);
    check("drop_status", st, 32'h010C_0002);
    wr(3'd4, 32'd0);
    idle(1);
    rd_status(st);
    check("drop_cleared", st, 32'h010C_0000);

    // A COLOR write coinciding with the last fill pixel counts as busy.
    wr(3'd3, 32'd2);
    idle(1);
    check("last_busy", {31'd0, busy}, 32'd1);
    wr(3'd2, 32'h0000_0055);
    idle(1);
    rd_status(st);
    check("last_drop_status", st, 32'h010E_0002);
    wr(3'd4, 32'd0);
    wr(3'd3, 32'd1);
    check("color_kept", {8'd0, bram_wdata, bram_addr}, 32'h0003_010E);
    wait_idle(5);

    // FILL 0 is a no-op.
    base = wr_cnt;
    wr(3'd3, 32'd0);
    check("fill0_busy", {30'd0, busy, bram_en}, 32'd0);
    idle(2);
    check("fill0_count", wr_cnt - base, 0);

    // Large fill from 0.
    wr(3'd0, 32'd0);
    base = wr_cnt;
    wr(3'd3, 32'd49152);
    wait_idle(50000);
    check("big_count", wr_cnt - base, 49152);
    rd_status(st);
    check("big_status", st, 32'hC000_0000);

    // Reset in the middle of a fill of 100.
    wr(3'd0, 32'h0000_0200);
    wr(3'd3, 32'd100);
    idle(10);
    #2 resetn = 1'b0;
    #1;
    check("rstfill_we",    {30'd0, bram_we, bram_en}, 32'd0);
    check("rstfill_busy",  {31'd0, busy}, 32'd0);
    check("rstfill_rdata", rdata, 32'd0);
    base = wr_cnt;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    idle(5);
    check("rstfill_count", wr_cnt - base, 0);
    rd_status(st);
    check("rstfill_status", st, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
